// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache. Hits are served combinationally
// from the line array. A miss stalls the fetch stage, pulls the whole 16-byte
// block from instruction memory, installs it and then serves the word.
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 6 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                           state;
  logic [LINES-1:0]                 valid;
  logic [LINES-1:0][TAG_W-1:0]      tag_array;
  logic [LINES-1:0][127:0]          data_array;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            wsel;
  logic                  hit;
  logic [INDEX_BITS-1:0] index_l;
  logic [TAG_W-1:0]      tag_l;
  logic                  unused_bits;

  assign index       = address[4+INDEX_BITS-1:4];
  assign tag         = address[9:4+INDEX_BITS];
  assign wsel        = address[3:2];
  // byte offset is dropped: misaligned PCs read the enclosing word
  assign unused_bits = ^address[1:0];

  // fill target comes from the latched block address, never the live PC
  assign index_l = mem_address[INDEX_BITS-1:0];
  assign tag_l   = mem_address[5:INDEX_BITS];

  // lookup, stall and word select are purely combinational
  always_comb begin
    hit         = valid[index] && (tag_array[index] == tag);
    busywait    = (state == IDLE) ? !hit : 1'b1;
    instruction = busywait ? 32'h0 : data_array[index][{wsel, 5'b0} +: 32];
  end

  // miss FSM: owns state, valid bits and the registered memory request
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= '0;
      mem_read    <= 1'b0;
      mem_address <= 6'h0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            mem_address <= address[9:4];
            mem_read    <= 1'b1;
            state       <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            mem_read <= 1'b0;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          valid[index_l] <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // line install; arrays carry no reset, valid bits gate their contents
  always_ff @(posedge clock) begin
    if (!reset && state == UPDATE) begin
      tag_array[index_l]  <= tag_l;
      data_array[index_l] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a small block-memory model that
// holds busywait for three cycles after each read request.
module tb_instruction_cache;

  logic         clock = 1'b0;
  logic         reset;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int checks   = 0;
  int failures = 0;
  int cnt      = 0;
  int n;

  // posedge of miss + 3 busy cycles + 1 ready cycle + UPDATE = 5 edges after the miss edge
  localparam int FILL_N = 5;

  instruction_cache #(.INDEX_BITS(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] blk_data(input logic [5:0] b);
    case (b)
      6'd0: blk_data = {32'h03060304, 32'h02050304, 32'h00040005, 32'h00030020};
      6'd1: blk_data = {32'h00020006, 32'h22222222, 32'h11111111, 32'h00070003};
      default: blk_data = {16'hBEEF, 2'b0, b, 8'h03, 16'hBEEF, 2'b0, b, 8'h02,
                           16'hBEEF, 2'b0, b, 8'h01, 16'hBEEF, 2'b0, b, 8'h00};
    endcase
  endfunction

  // memory: busy combinationally from mem_read for the first three cycles
  always @(posedge clock) cnt <= mem_read ? cnt + 1 : 0;
  assign mem_busywait = mem_read && (cnt < 3);
  assign mem_readdata = blk_data(mem_address);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // bounded wait for the stall to clear; returns edges taken
  task automatic wait_fill(output int cyc);
    cyc = 0;
    while (busywait && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  // present a PC, expect an immediate hit
  task automatic hit_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk({tag, "_bw"}, 32'(busywait), 32'd0);
    chk({tag, "_ins"}, instruction, exp);
    chk({tag, "_mr"}, 32'(mem_read), 32'd0);
  endtask

  // present a PC, expect a miss and a request for block blk on the next edge
  task automatic miss_chk(input string tag, input logic [9:0] a, input logic [5:0] blk);
    address = a;
    #1;
    chk({tag, "_bw"}, 32'(busywait), 32'd1);
    chk({tag, "_ins0"}, instruction, 32'h0);
    tick();
    chk({tag, "_mr"}, 32'(mem_read), 32'd1);
    chk({tag, "_ma"}, 32'(mem_address), 32'(blk));
  endtask

  initial begin
    reset   = 1'b1;
    address = 10'h000;
    tick();
    tick();
    // reset state: nothing valid, so address 0 misses
    chk("rst_mr", 32'(mem_read), 32'd0);
    chk("rst_ma", 32'(mem_address), 32'd0);
    chk("rst_bw", 32'(busywait), 32'd1);
    reset = 1'b0;

    // cold miss on block 0
    miss_chk("cold", 10'h000, 6'd0);
    wait_fill(n);
    chk("cold_lat", n, FILL_N);
    chk("cold_ins", instruction, 32'h00030020);
    chk("cold_mr", 32'(mem_read), 32'd0);

    // hits in the same block on consecutive cycles
    hit_chk("h4", 10'h004, 32'h00040005);
    tick();
    hit_chk("h8", 10'h008, 32'h02050304);
    tick();
    hit_chk("hc", 10'h00C, 32'h03060304);
    tick();

    // second block
    miss_chk("b1", 10'h010, 6'd1);
    wait_fill(n);
    chk("b1_lat", n, FILL_N);
    chk("b1_ins", instruction, 32'h00070003);
    hit_chk("h1c", 10'h01C, 32'h00020006);
    hit_chk("h1f", 10'h01F, 32'h00020006);
    tick();

    // conflict: block 8 shares index 0 with block 0
    miss_chk("b8", 10'h080, 6'd8);
    wait_fill(n);
    chk("b8_lat", n, FILL_N);
    chk("b8_ins", instruction, 32'hBEEF0800);
    miss_chk("evict", 10'h000, 6'd0);
    wait_fill(n);
    chk("evict_lat", n, FILL_N);
    chk("evict_ins", instruction, 32'h00030020);
    hit_chk("b1_kept", 10'h010, 32'h00070003);
    tick();

    // reset while in MEM_READ drops the fill and invalidates everything
    miss_chk("rmid", 10'h080, 6'd8);
    reset = 1'b1;
    tick();
    chk("rmid_mr", 32'(mem_read), 32'd0);
    chk("rmid_ma", 32'(mem_address), 32'd0);
    reset = 1'b0;
    miss_chk("refetch", 10'h004, 6'd0);
    wait_fill(n);
    chk("refetch_lat", n, FILL_N);
    chk("refetch_ins", instruction, 32'h00040005);

    // PC moves during the stall to a cached block: latched block still fills
    miss_chk("mv1", 10'h010, 6'd1);
    address = 10'h000;
    wait_fill(n);
    chk("mv1_lat", n, FILL_N);
    chk("mv1_ins", instruction, 32'h00030020);
    hit_chk("mv1_b1", 10'h010, 32'h00070003);
    tick();

    // PC moves during the stall to an uncached block: a fresh miss follows
    miss_chk("mv2", 10'h090, 6'd9);
    address = 10'h080;
    for (int i = 0; i < FILL_N; i++) tick();
    chk("mv2_bw", 32'(busywait), 32'd1);
    chk("mv2_mr", 32'(mem_read), 32'd0);
    tick();
    chk("mv2_mr2", 32'(mem_read), 32'd1);
    chk("mv2_ma", 32'(mem_address), 32'd8);
    wait_fill(n);
    chk("mv2_lat", n, FILL_N);
    chk("mv2_ins", instruction, 32'hBEEF0800);
    hit_chk("mv2_b9", 10'h098, 32'hBEEF0902);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
